// File: rtl/sum_display_driver.sv
// ============================================================================
// sum_display_driver : captures a 5-bit adder result and shows it in decimal
// on a 4-digit multiplexed active-low seven-segment display.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sum_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  input  logic       load_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int unsigned     CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       bin_q, bin_d;
  logic [3:0]       tens_bcd_q, tens_bcd_d;
  logic [3:0]       ones_bcd_q, ones_bcd_d;
  logic [2:0]       iter_q, iter_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0] tens_adj, ones_adj, tens_shift, ones_shift;
  logic       unused_tens_msb;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: add-3 correction, then shift the next binary bit in.
  assign tens_adj        = (tens_bcd_q >= 4'd5) ? tens_bcd_q + 4'd3 : tens_bcd_q;
  assign ones_adj        = (ones_bcd_q >= 4'd5) ? ones_bcd_q + 4'd3 : ones_bcd_q;
  assign tens_shift      = {tens_adj[2:0], ones_adj[3]};
  assign ones_shift      = {ones_adj[2:0], bin_q[4]};
  assign unused_tens_msb = tens_adj[3];

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    tens_bcd_d = tens_bcd_q;
    ones_bcd_d = ones_bcd_q;
    iter_d     = iter_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          bin_d      = {cout_i, sum_i};
          tens_bcd_d = 4'd0;
          ones_bcd_d = 4'd0;
          iter_d     = 3'd0;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        bin_d      = {bin_q[3:0], 1'b0};
        tens_bcd_d = tens_shift;
        ones_bcd_d = ones_shift;
        iter_d     = iter_q + 3'd1;
        if (iter_q == 3'd4) begin
          tens_d  = tens_shift;
          ones_d  = ones_shift;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan outputs are built from next-state values so an and seg move together.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0:    seg_d = seg7(ones_d);
      2'd1:    seg_d = (tens_d == 4'd0) ? SEG_BLANK : seg7(tens_d);
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      tens_bcd_q <= '0;
      ones_bcd_q <= '0;
      iter_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      tens_bcd_q <= tens_bcd_d;
      ones_bcd_q <= ones_bcd_d;
      iter_q     <= iter_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sum_display_driver.sv
// ============================================================================
// tb_sum_display_driver : randomized + directed bench for sum_display_driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sum_display_driver;

  localparam int DIV = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] sum_i = 4'd0;
  logic       cout_i = 1'b0;
  logic       load_i = 1'b0;
  logic       busy_o, done_o, dp_o;
  logic [3:0] an_o;
  logic [6:0] seg_o;

  sum_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sum_i  (sum_i),
    .cout_i (cout_i),
    .load_i (load_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase = cycles since capture (0 = idle), digits by /10 and %10,
  // scan index from elapsed cycles since reset.
  int m_t, m_phase, m_pend, m_disp;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_t     <= 0;
      m_phase <= 0;
      m_pend  <= 0;
      m_disp  <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_phase == 0) begin
        if (load_i) begin
          m_phase <= 1;
          m_pend  <= int'({cout_i, sum_i});
        end
      end else if (m_phase == 6) begin
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
      if (m_phase == 5) m_disp <= m_pend;
    end
  end

  function automatic int exp_seg(input int idx, input int v);
    if (idx == 0) return int'(seg_tab[v % 10]);
    if (idx == 1) return (v / 10 == 0) ? 7'h7f : int'(seg_tab[v / 10]);
    return 7'h7f;
  endfunction

  always @(negedge clk_i) begin
    int idx;
    logic [3:0] an_exp;
    idx    = (m_t / DIV) % 4;
    an_exp = ~(4'b0001 << idx);
    chk("m_busy", int'(busy_o), int'(m_phase != 0));
    chk("m_done", int'(done_o), int'(m_phase == 6));
    chk("m_an",   int'(an_o),   int'(an_exp));
    chk("m_seg",  int'(seg_o),  exp_seg(idx, m_disp));
    chk("m_dp",   int'(dp_o),   1);
  end

  task automatic show(input string nm, input int digit, input logic [6:0] exp);
    logic [3:0] want;
    bit found;
    want  = ~(4'b0001 << digit);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (an_o == want) found = 1;
    end
    if (!found) chk({nm, "_timeout"}, 0, 1);
    else        chk(nm, int'(seg_o), int'(exp));
  endtask

  task automatic load_val(input logic [4:0] v);
    {cout_i, sum_i} = v;
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    repeat (7) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_an",   int'(an_o),   4'b1110);
    chk("rst_seg",  int'(seg_o),  7'b1000000);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk_i);
      if (i == 3)  chk("scan_an3",  int'(an_o), 4'b1110);
      if (i == 4)  chk("scan_an4",  int'(an_o), 4'b1101);
      if (i == 4)  chk("scan_seg4", int'(seg_o), 7'b1111111);
      if (i == 8)  chk("scan_an8",  int'(an_o), 4'b1011);
      if (i == 12) chk("scan_an12", int'(an_o), 4'b0111);
      if (i == 15) chk("scan_an15", int'(an_o), 4'b0111);
    end

    // 31: busy/done timing relative to the capture edge
    {cout_i, sum_i} = 5'd31;
    load_i = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk_i);
      load_i = 1'b0;
      if (j == 1) chk("t2_busy_j1", int'(busy_o), 1);
      if (j == 1) chk("t2_done_j1", int'(done_o), 0);
      if (j == 5) chk("t2_done_j5", int'(done_o), 0);
      if (j == 6) chk("t2_done_j6", int'(done_o), 1);
      if (j == 6) chk("t2_busy_j6", int'(busy_o), 1);
      if (j == 7) chk("t2_busy_j7", int'(busy_o), 0);
    end
    show("t2_ones", 0, 7'b1111001);
    show("t2_tens", 1, 7'b0110000);

    load_val(5'd9);
    show("t3_ones", 0, 7'b0010000);
    show("t3_tens", 1, 7'b1111111);
    load_val(5'd10);
    show("t4_ones", 0, 7'b1000000);
    show("t4_tens", 1, 7'b1111001);
    load_val(5'd16);
    show("t4b_ones", 0, 7'b0000010);
    show("t4b_tens", 1, 7'b1111001);

    // 25 then a second strobe while busy
    {cout_i, sum_i} = 5'd25;
    load_i = 1'b1;
    dcnt = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk_i);
      load_i = 1'b0;
      if (j == 2) begin
        {cout_i, sum_i} = 5'd7;
        load_i = 1'b1;
      end
      if (done_o) dcnt++;
    end
    chk("t5_done_count", dcnt, 1);
    show("t5_ones", 0, 7'b0010010);
    show("t5_tens", 1, 7'b0100100);

    // 31 interrupted by reset after edge k+3
    {cout_i, sum_i} = 5'd31;
    load_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      load_i = 1'b0;
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_an",   int'(an_o),   4'b1110);
    chk("t6_seg",  int'(seg_o),  7'b1000000);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    dcnt = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o) dcnt++;
    end
    chk("t6_no_done", dcnt, 0);
    {cout_i, sum_i} = 5'd12;
    load_i = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk_i);
      load_i = 1'b0;
      if (j == 5) chk("t6_done_j5", int'(done_o), 0);
      if (j == 6) chk("t6_done_j6", int'(done_o), 1);
    end
    show("t6_ones", 0, 7'b0100100);
    show("t6_tens", 1, 7'b1111001);

    // randomized traffic, then a long held strobe
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      sum_i  = 4'($urandom_range(0, 15));
      cout_i = 1'($urandom_range(0, 1));
      load_i = ($urandom_range(0, 3) == 0);
    end
    load_i = 1'b1;
    repeat (30) begin
      @(negedge clk_i);
      sum_i  = 4'($urandom_range(0, 15));
      cout_i = 1'($urandom_range(0, 1));
    end
    load_i = 1'b0;
    repeat (20) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
